// File: rtl/gmii_mac_tx.sv
// gmii_mac_tx: GMII transmit framer; adds preamble/SFD, zero pad to MIN_FRAME,
// CRC-32 FCS and the inter-frame gap around a body read from a synchronous FIFO.
module gmii_mac_tx #(
  parameter int MIN_FRAME  = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic        tx_start_en,
  input  logic [15:0] tx_byte_num,
  input  logic [7:0]  tx_data,
  output logic        tx_req,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;
  localparam logic [16:0] MIN_W    = 17'(MIN_FRAME);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, n_q, n_d;
  logic [31:0] crc_q, crc_d;
  logic        tx_req_d, tx_busy_d, tx_done_d, gmii_tx_en_d;
  logic [7:0]  gmii_txd_d;
  logic        short_w;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {1'b0, r[31:1]} ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
  always_ff @(posedge gmii_tx_clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      crc_q      <= '1;
      tx_req     <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      crc_q      <= crc_d;
      tx_req     <= tx_req_d;
      tx_busy    <= tx_busy_d;
      tx_done    <= tx_done_d;
      gmii_tx_en <= gmii_tx_en_d;
      gmii_txd   <= gmii_txd_d;
    end
  // cnt counts body bytes continuously through DATA and PAD so PAD ends at MIN_FRAME
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    n_d     = n_q;
    short_w = {1'b0, n_q} < MIN_W;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_start_en) begin
          state_d = PREAMBLE;
          n_d     = tx_byte_num;
        end
      end
      PREAMBLE: if (cnt_q == 16'd6) begin
        state_d = SFD;
        cnt_d   = '0;
      end
      SFD: begin
        cnt_d   = '0;
        state_d = (n_q != '0) ? DATA : (MIN_FRAME > 0) ? PAD : FCS;
      end
      DATA: if (cnt_d == n_q) begin
        state_d = short_w ? PAD : FCS;
        cnt_d   = short_w ? cnt_d : '0;
      end
      PAD: if ({1'b0, cnt_d} == MIN_W) begin
        state_d = FCS;
        cnt_d   = '0;
      end
      FCS: if (cnt_q == 16'd3) begin
        state_d = IFG;
        cnt_d   = '0;
      end
      IFG: if (cnt_q == IFG_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  // outputs are decoded from the next state so they are registered alongside it
  always_comb begin
    tx_busy_d    = state_d != IDLE;
    tx_done_d    = state_d == IFG && cnt_d == '0;
    gmii_tx_en_d = state_d inside {PREAMBLE, SFD, DATA, PAD, FCS};
    gmii_txd_d   = state_d == PREAMBLE ? 8'h55 :
                   state_d == SFD      ? 8'hD5 :
                   state_d == DATA     ? tx_data :
                   state_d == FCS      ? ~crc_q[{cnt_d[1:0], 3'b000} +: 8] : 8'h00;
    tx_req_d     = (state_d == PREAMBLE && cnt_d == 16'd6 && n_q != '0) ||
                   (state_d == SFD && n_q > 16'd1) ||
                   (state_d == DATA && {1'b0, cnt_d} + 17'd3 <= {1'b0, n_q});
    crc_d        = state_d == PREAMBLE ? '1 :
                   (state_d inside {DATA, PAD}) ? crc_byte(crc_q, gmii_txd_d) : crc_q;
  end
endmodule

// File: tb/tb_gmii_mac_tx.sv
// tb_gmii_mac_tx: directed and randomized frames checked against a byte-level frame model;
// one default instance (MIN_FRAME=60) and one with padding disabled.
module tb_gmii_mac_tx;
  localparam int IFG = 12;
  logic        clk = 1'b0, rst_n = 1'b0, tx_start_en = 1'b0, sel = 1'b0, flush = 1'b1;
  logic [15:0] tx_byte_num = '0;
  logic [7:0]  d0 = '0, d1 = '0, p0 = '0, p1 = '0, txd0, txd1, m_txd;
  logic        req0, req1, busy0, busy1, done0, done1, en0, en1;
  logic        m_en, m_req, m_busy, m_done;
  logic [7:0]  mem [256];
  logic [7:0]  exp_q[$], got_q[$];
  int          checks = 0, errors = 0;
  always #4 clk = ~clk;
  gmii_mac_tx dut (
    .gmii_tx_clk(clk), .rst_n(rst_n), .tx_start_en(tx_start_en & ~sel), .tx_byte_num(tx_byte_num),
    .tx_data(d0), .tx_req(req0), .tx_busy(busy0), .tx_done(done0), .gmii_tx_en(en0), .gmii_txd(txd0)
  );
  gmii_mac_tx #(.MIN_FRAME(0), .IFG_CYCLES(12)) dut_nopad (
    .gmii_tx_clk(clk), .rst_n(rst_n), .tx_start_en(tx_start_en & sel), .tx_byte_num(tx_byte_num),
    .tx_data(d1), .tx_req(req1), .tx_busy(busy1), .tx_done(done1), .gmii_tx_en(en1), .gmii_txd(txd1)
  );
  assign m_en   = sel ? en1 : en0;
  assign m_txd  = sel ? txd1 : txd0;
  assign m_req  = sel ? req1 : req0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  always @(posedge clk)
    if (flush) begin
      p0 <= '0;
      p1 <= '0;
    end else begin
      if (req0) begin d0 <= mem[p0]; p0 <= p0 + 8'd1; end
      if (req1) begin d1 <= mem[p1]; p1 <= p1 + 8'd1; end
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
  task automatic build_exp(input int off, input int n, input int mf);
    logic [31:0] c;
    logic [7:0]  b;
    int          body;
    c = 32'hFFFFFFFF;
    body = n > mf ? n : mf;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < body; i++) begin
      b = (i < n) ? mem[off+i] : 8'h00;
      exp_q.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
  endtask
  task automatic cmp_bytes(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    chk(tag, bad, 0);
  endtask
  task automatic load_mem(input int n);
    for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
  endtask
  task automatic run_frame(input int n, input bit rnd);
    int mf, len, en_cnt, en_first, en_last, req_cnt, req_first, req_last, done_cyc, busy_first, busy_last;
    mf = sel ? 0 : 60;
    len = 12 + (n > mf ? n : mf);
    {en_cnt, en_first, en_last, req_cnt, req_first, req_last} = '0;
    {done_cyc, busy_first, busy_last} = '0;
    exp_q.delete();
    got_q.delete();
    build_exp(0, n, mf);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tx_byte_num = 16'(n);
    tx_start_en = 1'b1;
    for (int k = 1; k <= len + IFG + 3; k++) begin
      @(negedge clk);
      if (m_en) begin got_q.push_back(m_txd); en_cnt++; if (en_first == 0) en_first = k; en_last = k; end
      if (m_req) begin req_cnt++; if (req_first == 0) req_first = k; req_last = k; end
      if (m_done && done_cyc == 0) done_cyc = k;
      if (m_busy) begin if (busy_first == 0) busy_first = k; busy_last = k; end
      if (rnd) begin
        tx_byte_num = 16'($urandom);
        tx_start_en = (k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else tx_start_en = 1'b0;
    end
    chk("en_cnt", en_cnt, len);
    chk("en_first", en_first, 1);
    chk("en_last", en_last, len);
    chk("req_cnt", req_cnt, n);
    if (n > 0) begin
      chk("req_first", req_first, 7);
      chk("req_last", req_last, 6 + n);
    end
    chk("done_cyc", done_cyc, len + 1);
    chk("busy_first", busy_first, 1);
    chk("busy_last", busy_last, len + IFG);
    cmp_bytes("frame_bytes");
  endtask
  initial begin
    int   lens[$];
    int   cur;
    logic prev;
    repeat (2) @(negedge clk);
    chk("rst_outs", {en0, txd0, req0, busy0, done0, en1, txd1, req1, busy1, done1}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    sel = 1'b1;
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    run_frame(9, 1'b0);
    chk("fcs_check_vector", {got_q[20], got_q[19], got_q[18], got_q[17]}, 32'hCBF43926);
    run_frame(0, 1'b0);
    chk("fcs_empty_nopad", {got_q[11], got_q[10], got_q[9], got_q[8]}, 32'h0);
    load_mem(20);
    run_frame($urandom_range(1, 20), 1'b1);
    sel = 1'b0;
    load_mem(14);
    run_frame(14, 1'b0);
    run_frame(0, 1'b0);
    load_mem(61);
    run_frame(60, 1'b0);
    run_frame(61, 1'b0);
    for (int r = 0; r < 3; r++) begin
      load_mem(90);
      run_frame($urandom_range(0, 90), 1'b1);
    end
    load_mem(200);
    exp_q.delete();
    got_q.delete();
    build_exp(0, 100, 60);
    build_exp(100, 100, 60);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tx_byte_num = 16'd100;
    tx_start_en = 1'b1;
    prev = 1'b1;
    cur = 0;
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      if (en0) got_q.push_back(txd0);
      if (en0 == prev) cur++;
      else begin lens.push_back(cur); cur = 1; prev = en0; end
      tx_byte_num = (k >= 2 && k <= 100) ? 16'($urandom) : 16'd100;
      tx_start_en = k <= 125 ? 1'b1 : k <= 230 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    chk("b2b_runs", lens.size(), 3);
    chk("b2b_frame1_en", lens[0], 112);
    chk("b2b_gap", lens[1], 13);
    chk("b2b_frame2_en", lens[2], 112);
    cmp_bytes("b2b_bytes");
    repeat (15) @(negedge clk);
    load_mem(100);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tx_byte_num = 16'd100;
    tx_start_en = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      tx_start_en = 1'b0;
    end
    chk("pre_rst_en", en0, 1'b1);
    chk("pre_rst_txd", txd0, mem[19]);
    chk("pre_rst_req", req0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {en0, txd0, req0, busy0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {en0, busy0, req0}, 0);
    load_mem(64);
    run_frame(64, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gmii_mac_tx.md
# gmii_mac_tx

Ethernet MAC transmit framer that drives the GMII transmit side of the RGMII bridge (gmii_tx_en / gmii_txd, clocked by gmii_tx_clk). It takes a frame body from an upstream synchronous-read FIFO through a request interface. It prepends the 7-byte preamble and SFD, zero-pads short frames to the minimum length, appends the IEEE 802.3 CRC-32 FCS, and enforces the inter-frame gap.

## Interface
- MIN_FRAME, 60: minimum frame body length in bytes (DA through pad, excluding FCS); 0 disables padding.
- IFG_CYCLES, 12: idle cycles with gmii_tx_en low after the last FCS byte.

- gmii_tx_clk  in  1  125 MHz GMII transmit clock; all logic in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- tx_start_en  in  1  frame request; sampled only in IDLE.
- tx_byte_num  in  16  frame body length N (DA..payload, excluding pad/FCS); captured with tx_start_en.
- tx_data  in  8  body byte; valid the cycle after tx_req is high (synchronous FIFO read).
- tx_req  out  1  read strobe to upstream, one byte per high cycle.
- tx_busy  out  1  high from the cycle after acceptance through the last IFG cycle.
- tx_done  out  1  one-cycle pulse in the first IFG cycle.
- gmii_tx_en  out  1  GMII transmit enable.
- gmii_txd  out  8  GMII transmit data.

## Operation
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE, CRC to 0xFFFFFFFF, counters to 0.
- FSM: IDLE -> PREAMBLE (7 cycles, 0x55) -> SFD (1 cycle, 0xD5) -> DATA (N cycles) -> PAD (max(0, MIN_FRAME−N) cycles, 0x00) -> FCS (4 cycles) -> IFG (IFG_CYCLES cycles) -> IDLE.
- N=0: DATA is skipped and the body is MIN_FRAME pad bytes. N=0 with MIN_FRAME=0 goes SFD -> FCS, giving FCS 0x00,0x00,0x00,0x00 (~0xFFFFFFFF).
- In IDLE, tx_start_en=1 captures tx_byte_num and enters PREAMBLE. tx_start_en in any other state is ignored. tx_byte_num changes after capture have no effect.
- The byte counter is 16 bits and compares against the captured N. No maximum-length check; N up to 65535 is transmitted as given.
- CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated over every DATA and PAD byte, LSB first. FCS = ~crc, sent as bits[7:0] first, then [15:8], [23:16], [31:24].
- CRC is re-initialised on entry to PREAMBLE.
- tx_req issues exactly N strobes per frame, never during PAD/FCS/IFG/IDLE.
- gmii_tx_en is high for exactly 8 + max(N, MIN_FRAME) + 4 consecutive cycles per frame.
- Reset mid-frame: all outputs clear asynchronously and the frame is truncated with no FCS. After release the block is in IDLE. It never resumes the truncated frame; the upstream FIFO flush is the upstream's responsibility.

## Timing
- Cycle 0: tx_start_en sampled high in IDLE.
- Cycles 1–7: preamble. Cycle 8: SFD. tx_busy rises in cycle 1.
- tx_req is high in cycles 7 … 6+N. Body byte i (1..N) is returned by the FIFO in cycle 7+i and appears on gmii_txd in cycle 8+i.
- Pad in cycles 9+N … 8+max(N,MIN_FRAME). FCS occupies the next 4 cycles.
- tx_done pulses in the first cycle with gmii_tx_en low. tx_busy falls after the last IFG cycle.
- Back-to-back: with tx_start_en held high, the gap between frames is IFG_CYCLES+1 = 13 cycles of gmii_tx_en low (IFG plus one IDLE acceptance cycle).

## Test plan
- MIN_FRAME=0, N=9, body "123456789" (0x31..0x39) -> gmii_txd = 55×7, D5, 31..39, 26 39 F4 CB. gmii_tx_en high for 21 cycles (1..21). tx_req high exactly 9 cycles (7..15). tx_done at cycle 22.
- Defaults, N=14 random body -> 46 bytes of 0x00 pad, gmii_tx_en high 72 cycles. A reference CRC over body+pad+FCS gives residue 0xC704DD7B.
- Defaults, N=0 -> 60 pad bytes, 4 FCS bytes, zero tx_req strobes, gmii_tx_en high 72 cycles.
- tx_start_en held high, N=100 for two frames -> each frame has gmii_tx_en high 112 cycles, with exactly 13 low cycles between frames. Pulsing tx_start_en and changing tx_byte_num mid-frame alters neither frame.
- rst_n asserted during DATA byte 20 of N=100 -> gmii_tx_en, gmii_txd, tx_req, tx_busy go 0 without waiting for a clock edge. After release, a new start with N=64 yields a complete, CRC-correct 76-cycle frame.
